// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer family.
package demux_pkg;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;
    localparam int   ERR_CNT_W = 8;

    // Select width that never collapses to zero bits, even for a single channel.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_stream.sv
// 1-to-N registered stream demultiplexer with addressed and round-robin routing.
// One holding register feeds the selected output channel; unselected channels read zero.
module demux_stream
    import demux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int SELW = clog2_min1(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 mode,
    output logic [N*W-1:0]       out_data,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [SELW-1:0]      rr_ptr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [SELW:0]   N_L     = N[SELW:0];
    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

    logic [W-1:0]         data_q;
    logic [SELW-1:0]      dest_q;
    logic                 full_q;
    logic [SELW-1:0]      rr_q;
    logic [ERR_CNT_W-1:0] err_q;

    logic            drain;
    logic            accept;
    logic [SELW-1:0] next_dest;
    logic            dest_ok;

    // Handshake: a beat moves on any edge where valid && ready are both high.
    // in_ready passes the selected consumer's ready through, so a held beat can
    // drain and a new beat load on the same edge (one beat per cycle).
    assign drain     = full_q && out_ready[dest_q];
    assign in_ready  = !full_q || out_ready[dest_q];
    assign accept    = in_valid && in_ready;
    assign next_dest = (mode == MODE_RR) ? rr_q : in_sel;
    assign dest_ok   = ({1'b0, next_dest} < N_L);

    assign rr_ptr  = rr_q;
    assign err_cnt = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            dest_q <= '0;
            full_q <= 1'b0;
            rr_q   <= '0;
            err_q  <= '0;
        end else begin
            // An out-of-range beat is swallowed, so a concurrent drain still empties.
            if (accept && dest_ok) begin
                data_q <= in_data;
                dest_q <= next_dest;
                full_q <= 1'b1;
            end else if (drain) begin
                full_q <= 1'b0;
            end

            if (accept && (mode == MODE_RR)) begin
                rr_q <= (rr_q == LAST_CH) ? '0 : rr_q + 1'b1;
            end

            if (accept && !dest_ok && (err_q != '1)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    // Outputs depend only on the holding register, so they are glitch-free per cycle.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (full_q && (dest_q == SELW'(k))) begin
                out_valid[k]        = 1'b1;
                out_data[k*W +: W]  = data_q;
            end
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
// Directed and soak bench for demux_stream using three configurations:
// N=4/W=8 (routing, backpressure, reset), N=5/W=8 (out-of-range), N=3/W=16 (soak).
module tb_demux_stream;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // N=4, W=8
    logic [7:0]  a_data;
    logic        a_valid, a_ir, a_mode;
    logic [1:0]  a_sel, a_rr;
    logic [31:0] a_od;
    logic [3:0]  a_ov, a_oready;
    logic [7:0]  a_err;

    // N=5, W=8
    logic [7:0]  b_data;
    logic        b_valid, b_ir, b_mode;
    logic [2:0]  b_sel, b_rr;
    logic [39:0] b_od;
    logic [4:0]  b_ov, b_oready;
    logic [7:0]  b_err;

    // N=3, W=16
    logic [15:0] c_data;
    logic        c_valid, c_ir, c_mode;
    logic [1:0]  c_sel, c_rr;
    logic [47:0] c_od;
    logic [2:0]  c_ov, c_oready;
    logic [7:0]  c_err;

    logic [17:0] exp_q[$];
    logic [1:0]  m_rr;
    int          m_err;

    demux_stream #(.N(4), .W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ir),
        .in_sel(a_sel), .mode(a_mode), .out_data(a_od), .out_valid(a_ov),
        .out_ready(a_oready), .rr_ptr(a_rr), .err_cnt(a_err)
    );

    demux_stream #(.N(5), .W(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ir),
        .in_sel(b_sel), .mode(b_mode), .out_data(b_od), .out_valid(b_ov),
        .out_ready(b_oready), .rr_ptr(b_rr), .err_cnt(b_err)
    );

    demux_stream #(.N(3), .W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ir),
        .in_sel(c_sel), .mode(c_mode), .out_data(c_od), .out_valid(c_ov),
        .out_ready(c_oready), .rr_ptr(c_rr), .err_cnt(c_err)
    );

    // Clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver plus scoreboard step for the N=3 soak; model state is the expected queue.
    task automatic soak_step(input bit idle);
        logic [17:0] head;
        logic [63:0] exp_ov;
        logic [63:0] exp_od;
        logic        exp_ready;
        logic [1:0]  d;
        c_valid  = idle ? 1'b0 : 1'($urandom_range(0, 1));
        c_data   = 16'($urandom_range(0, 65535));
        c_sel    = 2'($urandom_range(0, 3));
        c_mode   = 1'($urandom_range(0, 1));
        c_oready = idle ? 3'h7 : 3'($urandom_range(0, 7));
        #1;
        if (exp_q.size() != 0) begin
            head      = exp_q[0];
            exp_ov    = 64'(1) << head[17:16];
            exp_od    = 64'(head[15:0]) << (16 * int'(head[17:16]));
            exp_ready = c_oready[head[17:16]];
        end else begin
            head      = '0;
            exp_ov    = '0;
            exp_od    = '0;
            exp_ready = 1'b1;
        end
        chk("soak_out_valid", 64'(c_ov), exp_ov);
        chk("soak_out_data", 64'(c_od), exp_od);
        chk("soak_in_ready", 64'(c_ir), 64'(exp_ready));
        chk("soak_onehot", 64'($countones(c_ov) <= 1), 64'(1));
        if ((exp_q.size() != 0) && c_oready[head[17:16]]) begin
            void'(exp_q.pop_front());
        end
        if (c_valid && exp_ready) begin
            if (c_mode) begin
                d    = m_rr;
                m_rr = (m_rr == 2'd2) ? 2'd0 : m_rr + 2'd1;
            end else begin
                d = c_sel;
            end
            if (d < 2'd3) exp_q.push_back({d, c_data});
            else if (m_err != 255) m_err++;
        end
        tick();
    endtask

    logic [3:0]  ev2 [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic [31:0] ed2 [4] = '{32'h000000A0, 32'h0000A100, 32'h00A20000, 32'hA3000000};
    logic [3:0]  ev3 [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    logic [1:0]  er3 [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [31:0] ed3 [6] = '{32'h000000B0, 32'h0000B100, 32'h00B20000,
                            32'hB3000000, 32'h000000B4, 32'h0000B500};

    initial begin
        // Reset block
        rst_n = 1'b0;
        a_data = '0; a_valid = 1'b0; a_sel = '0; a_mode = 1'b0; a_oready = '0;
        b_data = '0; b_valid = 1'b0; b_sel = '0; b_mode = 1'b0; b_oready = '0;
        c_data = '0; c_valid = 1'b0; c_sel = '0; c_mode = 1'b0; c_oready = '0;
        m_rr = '0; m_err = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        chk("rst_out_valid", 64'(a_ov), 64'(0));
        chk("rst_out_data", 64'(a_od), 64'(0));
        chk("rst_in_ready", 64'(a_ir), 64'(1));
        chk("rst_rr_ptr", 64'(a_rr), 64'(0));
        chk("rst_err_cnt", 64'(a_err), 64'(0));

        // Addressed streaming, one beat per cycle
        a_oready = 4'hF;
        a_mode   = 1'b0;
        a_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = 8'hA0 + 8'(i);
            a_sel  = 2'(i);
            #1;
            chk("addr_in_ready", 64'(a_ir), 64'(1));
            tick();
            chk("addr_out_valid", 64'(a_ov), 64'(ev2[i]));
            chk("addr_out_data", 64'(a_od), 64'(ed2[i]));
        end
        a_valid = 1'b0;
        tick();
        chk("addr_drained", 64'(a_ov), 64'(0));

        // Round-robin wrap; in_sel is ignored in this mode
        chk("rr_start", 64'(a_rr), 64'(0));
        a_mode  = 1'b1;
        a_sel   = 2'd2;
        a_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_data = 8'hB0 + 8'(i);
            tick();
            chk("rr_out_valid", 64'(a_ov), 64'(ev3[i]));
            chk("rr_out_data", 64'(a_od), 64'(ed3[i]));
            chk("rr_ptr", 64'(a_rr), 64'(er3[i]));
        end
        a_mode = 1'b0;
        a_sel  = 2'd3;
        a_data = 8'hC3;
        tick();
        chk("mode_sw_out_valid", 64'(a_ov), 64'(4'h8));
        chk("mode_sw_out_data", 64'(a_od), 64'(32'hC3000000));
        chk("mode_sw_rr_hold", 64'(a_rr), 64'(2));
        a_valid = 1'b0;
        tick();

        // Backpressure on ch2; other channels' ready is ignored
        a_oready = 4'b1011;
        a_valid  = 1'b1;
        a_sel    = 2'd2;
        a_data   = 8'hD2;
        tick();
        chk("bp_out_valid", 64'(a_ov), 64'(4'h4));
        a_sel  = 2'd1;
        a_data = 8'hE1;
        #1;
        chk("bp_in_ready_low", 64'(a_ir), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", 64'(a_ov), 64'(4'h4));
            chk("bp_hold_slice", 64'(a_od[23:16]), 64'(8'hD2));
            chk("bp_hold_data", 64'(a_od), 64'(32'h00D20000));
            chk("bp_hold_ready", 64'(a_ir), 64'(0));
        end
        a_oready = 4'hF;
        #1;
        chk("bp_release_ready", 64'(a_ir), 64'(1));
        tick();
        chk("bp_b2b_valid", 64'(a_ov), 64'(4'h2));
        chk("bp_b2b_data", 64'(a_od), 64'(32'h0000E100));
        a_valid = 1'b0;
        tick();
        chk("bp_drained", 64'(a_ov), 64'(0));

        // Out-of-range on N=5
        b_oready = 5'h1F;
        b_mode   = 1'b0;
        b_valid  = 1'b1;
        b_data   = 8'h11;
        b_sel    = 3'd6;
        #1;
        chk("oor_in_ready", 64'(b_ir), 64'(1));
        tick();
        chk("oor6_valid", 64'(b_ov), 64'(0));
        chk("oor6_err", 64'(b_err), 64'(1));
        b_sel = 3'd7;
        tick();
        chk("oor7_valid", 64'(b_ov), 64'(0));
        chk("oor7_err", 64'(b_err), 64'(2));
        chk("oor7_in_ready", 64'(b_ir), 64'(1));
        b_sel  = 3'd4;
        b_data = 8'h5A;
        tick();
        chk("n5_ch4_valid", 64'(b_ov), 64'(5'h10));
        chk("n5_ch4_data", 64'(b_od), 64'(40'h5A00000000));
        b_sel  = 3'd5;
        b_data = 8'h77;
        tick();
        chk("oor_drain_valid", 64'(b_ov), 64'(0));
        chk("oor_drain_data", 64'(b_od), 64'(0));
        chk("oor_drain_err", 64'(b_err), 64'(3));
        repeat (251) tick();
        chk("oor_err_254", 64'(b_err), 64'(254));
        repeat (8) tick();
        chk("oor_err_sat", 64'(b_err), 64'(255));
        b_valid = 1'b0;

        // Asynchronous reset with a beat held on dut4
        a_oready = 4'b1101;
        a_valid  = 1'b1;
        a_sel    = 2'd1;
        a_data   = 8'h9C;
        tick();
        chk("pre_rst_held", 64'(a_ov), 64'(4'h2));
        chk("pre_rst_rr", 64'(a_rr), 64'(2));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(a_ov), 64'(0));
        chk("arst_out_data", 64'(a_od), 64'(0));
        chk("arst_in_ready", 64'(a_ir), 64'(1));
        chk("arst_rr_ptr", 64'(a_rr), 64'(0));
        chk("arst_err_cnt", 64'(b_err), 64'(0));
        a_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 64'(a_ov), 64'(0));

        // Random soak on N=3, W=16, then drain
        for (int i = 0; i < 600; i++) soak_step(1'b0);
        for (int i = 0; i < 4; i++) soak_step(1'b1);
        chk("soak_empty", 64'(exp_q.size()), 64'(0));
        chk("soak_rr_ptr", 64'(c_rr), 64'(m_rr));
        chk("soak_err_cnt", 64'(c_err), 64'(m_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
Parametrised 1-to-N stream demultiplexer, the registered successor of the 4-way combinational demux. It routes W-bit beats from one valid/ready input to one of N valid/ready outputs through a single output register stage. Two routing modes are supported: addressed (by in_sel) and round-robin. It sits between a single producer and N consumer channels in the datapath.

Parameters:
N, 4, number of output channels (2..16)
W, 8, data width in bits (1..64)
SELW, $clog2(N), select width; derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  W  input beat
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_sel  input  SELW  destination channel in addressed mode
mode  input  1  0 = addressed, 1 = round-robin; sampled at accept
out_data  output  N*W  channel k occupies bits [k*W +: W]
out_valid  output  N  per-channel valid; at most one bit set
out_ready  input  N  per-channel ready
rr_ptr  output  SELW  next round-robin destination
err_cnt  output  8  saturating count of dropped out-of-range beats

Behaviour:
- One clock and one reset. The reset is asynchronous and active-low (rst_n) and is fixed as such.
- Reset values: out_valid = 0, out_data = 0, rr_ptr = 0, err_cnt = 0, internal dest = 0. in_ready is 1 coming out of reset.
- Asserting rst_n mid-transfer discards any held beat immediately. No partial state survives reset.
- Storage is a single holding register: data_q, dest_q (SELW bits) and full_q.
- Output is registered:
  - out_valid[k] = full_q && (dest_q == k).
  - out_data slice dest_q = data_q. All other slices = 0, so the zero-on-unselected behaviour of the old demux is kept.
- in_ready = !full_q || out_ready[dest_q]. This is pass-through backpressure, so full throughput is 1 beat/cycle while the consumer stays ready.
- Accept = in_valid && in_ready. Destination on accept:
  - mode = 0: dest = in_sel.
  - mode = 1: dest = rr_ptr.
- Out-of-range (mode 0, in_sel >= N; possible only when N is not a power of 2):
  - The beat is accepted and dropped. full_q is not set by it.
  - err_cnt increments and saturates at 255.
  - in_ready behaviour is unchanged.
- Round-robin pointer:
  - rr_ptr advances by 1 on each accepted beat in mode 1 and wraps from N-1 to 0.
  - Accepts in mode 0 leave rr_ptr unchanged.
- Register update each cycle:
  - Drain only (out_ready[dest_q] && full_q && !accept): full_q goes to 0.
  - Accept with a valid destination: data_q, dest_q and full_q = 1 load, overwriting a beat that drains in the same cycle.
  - Simultaneous drain and accept gives back-to-back transfer with no bubble.
- Latency: a beat accepted in cycle t appears on out_valid in cycle t+1.
- Stall: while full_q && !out_ready[dest_q], data_q and dest_q hold stable and out_valid holds. out_ready of the other channels is ignored (head-of-line blocking is intended).
- Mode may change on any cycle. It affects only beats accepted in that cycle, never the beat already held.
- in_data and in_sel are don't-care when in_valid = 0. out_ready bits of non-selected channels are don't-care.

Decomposition:
- Shared package demux_pkg:
  - MODE_ADDR = 1'b0, MODE_RR = 1'b1.
  - ERR_CNT_W = 8.
  - Function clog2_min1, returning at least 1 for N = 1 safety.
- No sub-module is needed. The round-robin pointer and holding register are small enough to stay inline.
- Optional sub-module: demux_rr_ptr (wrap counter, parameter N), if it is reused by a future mux arbiter.

Test Plan:
1. Reset: hold rst_n = 0 mid-transfer with full_q = 1 -> out_valid = 0, rr_ptr = 0, err_cnt = 0, in_ready = 1, all asynchronous (checked before the next clk edge).
2. Addressed streaming, N = 4, W = 8: send 0xA0..0xA3 with in_sel 0,1,2,3 and all out_ready = 1 -> out_valid = 0001,0010,0100,1000 on consecutive cycles, each one cycle after accept, other slices 0, in_ready held at 1.
3. Round-robin wrap: mode = 1, send 6 beats -> destinations 0,1,2,3,0,1, rr_ptr = 2 at the end. Then switch to mode = 0 with sel = 3 -> beat goes to ch3 and rr_ptr stays 2.
4. Backpressure: beat to ch2 with out_ready[2] = 0 for 3 cycles -> in_ready = 0 and out_data[23:16] stable for 3 cycles. Raise out_ready[2] while in_valid = 1 -> drain and accept in the same cycle, no bubble.
5. Out-of-range: N = 5, in_sel = 6 and 7 -> no out_valid, err_cnt goes 0→2. Then drive 260 bad beats -> err_cnt = 255 (saturated).
6. Random soak, N = 3, W = 16: random in_valid, out_ready, mode and sel against a scoreboard -> no beat lost, duplicated or misrouted, and at most one out_valid bit set at any time.
